// File: rtl/lif_neuron_array.sv
`timescale 1ns/1ps
// Array of N leaky integrate-and-fire neurons driven one timestep per EN strobe.
// Spikes are presented on NEURON_OUT under a REQ/ACK handshake with backpressure.
module lif_neuron_array #(
   parameter int N_NEURON = 16,
   parameter int DV_W     = 10,
   parameter int V_W      = 7,
   parameter int VTH_W    = 6,
   parameter int REF_W    = 3
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [N_NEURON*(VTH_W+1)-1:0] NCFG,
   input  logic                          PD,
   input  logic                          SWP,
   input  logic                          RESET_MODE,
   input  logic [V_W-2:0]                LEAK,
   input  logic [REF_W-1:0]              REFRAC,
   input  logic                          EN,
   input  logic                          FT,
   input  logic [N_NEURON*DV_W-1:0]      DV,
   input  logic                          ACK,
   output logic                          REQ,
   output logic [N_NEURON-1:0]           NEURON_OUT,
   output logic                          BUSY,
   output logic                          EN_DROP
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_INTEG = 2'd1;
   localparam logic [1:0] ST_FIRE  = 2'd2;
   localparam logic [1:0] ST_OUT   = 2'd3;

   localparam int SUM_W = ((V_W > DV_W) ? V_W : DV_W) + 1;
   localparam int CMP_W = ((V_W > VTH_W + 1) ? V_W : VTH_W + 1) + 1;
   localparam int VMAX  = (2 ** (V_W - 1)) - 1;
   localparam logic signed [SUM_W-1:0] VMAX_S = SUM_W'(VMAX);

   logic [1:0]               state_reg;
   logic [1:0]               state_next;
   logic                     ft_reg;
   logic [N_NEURON*DV_W-1:0] dv_reg;
   logic                     req_reg;
   logic [N_NEURON-1:0]      out_reg;
   logic                     drop_reg;
   logic [N_NEURON-1:0]      spike_vec;

   // Add, clamp to +/-VMAX, then pull toward zero by lk without crossing it.
   function automatic logic signed [V_W-1:0] integ_step(
      input logic signed [V_W-1:0]  v,
      input logic signed [DV_W-1:0] d,
      input logic [V_W-2:0]         lk
   );
      logic signed [SUM_W-1:0] s;
      logic signed [SUM_W-1:0] l;
      s = {{(SUM_W-V_W){v[V_W-1]}}, v} + {{(SUM_W-DV_W){d[DV_W-1]}}, d};
      if (s > VMAX_S)
         s = VMAX_S;
      else if (s < -VMAX_S)
         s = -VMAX_S;
      l = {{(SUM_W-V_W+1){1'b0}}, lk};
      if (s > l)
         s = s - l;
      else if (s < -l)
         s = s + l;
      else
         s = '0;
      return s[V_W-1:0];
   endfunction

   function automatic logic fire_test(
      input logic signed [V_W-1:0] v,
      input logic [VTH_W-1:0]      vth,
      input logic                  swp
   );
      logic signed [CMP_W-1:0] ve;
      logic signed [CMP_W-1:0] te;
      ve = {{(CMP_W-V_W){v[V_W-1]}}, v};
      te = {{(CMP_W-VTH_W){1'b0}}, vth};
      return swp ? (ve <= -te) : (ve >= te);
   endfunction

   // Only called for a firing neuron, so the result always lies within +/-VMAX.
   function automatic logic signed [V_W-1:0] sub_reset(
      input logic signed [V_W-1:0] v,
      input logic [VTH_W-1:0]      vth,
      input logic                  swp
   );
      logic signed [CMP_W-1:0] ve;
      logic signed [CMP_W-1:0] te;
      logic signed [CMP_W-1:0] r;
      ve = {{(CMP_W-V_W){v[V_W-1]}}, v};
      te = {{(CMP_W-VTH_W){1'b0}}, vth};
      r  = swp ? (ve + te) : (ve - te);
      return r[V_W-1:0];
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < N_NEURON; gi++) begin : g_neuron
         logic signed [V_W-1:0]  v_reg;
         logic [REF_W-1:0]       cnt_reg;
         logic                   enb;
         logic [VTH_W-1:0]       vth;
         logic                   active;
         logic signed [DV_W-1:0] dv;
         logic signed [V_W-1:0]  v_pre;
         logic [REF_W-1:0]       cnt_pre;
         logic signed [V_W-1:0]  v_integ;
         logic signed [V_W-1:0]  v_fire;
         logic                   spike;

         assign {enb, vth} = NCFG[gi*(VTH_W+1) +: VTH_W+1];
         assign active     = !enb && !PD;
         assign dv         = dv_reg[gi*DV_W +: DV_W];

         always_comb begin
            v_pre   = ft_reg ? '0 : v_reg;
            cnt_pre = ft_reg ? '0 : cnt_reg;
            v_integ = integ_step(v_pre, dv, LEAK);
            spike   = active && (cnt_reg == '0) && fire_test(v_reg, vth, SWP);
            v_fire  = RESET_MODE ? sub_reset(v_reg, vth, SWP) : '0;
         end

         assign spike_vec[gi] = spike;

         // Inactive neurons keep v and counter frozen, including across FT.
         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               v_reg   <= '0;
               cnt_reg <= '0;
            end else if (active) begin
               if (state_reg == ST_INTEG) begin
                  if (cnt_pre == '0) begin
                     v_reg   <= v_integ;
                     cnt_reg <= '0;
                  end else begin
                     v_reg   <= v_pre;
                     cnt_reg <= cnt_pre - REF_W'(1);
                  end
               end else if (state_reg == ST_FIRE && spike) begin
                  v_reg   <= v_fire;
                  cnt_reg <= REFRAC;
               end
            end
         end
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (EN) state_next = ST_INTEG;
         ST_INTEG: state_next = ST_FIRE;
         ST_FIRE:  state_next = ST_OUT;
         ST_OUT:   if (ACK) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         ft_reg    <= 1'b0;
         dv_reg    <= '0;
         req_reg   <= 1'b0;
         out_reg   <= '0;
         drop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (EN && state_reg != ST_IDLE)
            drop_reg <= 1'b1;
         if (state_reg == ST_IDLE && EN) begin
            dv_reg <= DV;
            ft_reg <= FT;
         end
         if (state_reg == ST_FIRE) begin
            out_reg <= spike_vec;
            req_reg <= 1'b1;
         end
         // NEURON_OUT keeps its last value after the handshake completes.
         if (state_reg == ST_OUT && ACK)
            req_reg <= 1'b0;
      end
   end

   assign REQ        = req_reg;
   assign NEURON_OUT = out_reg;
   assign BUSY       = (state_reg != ST_IDLE);
   assign EN_DROP    = drop_reg;

endmodule

// File: tb/tb_lif_neuron_array.sv
`timescale 1ns/1ps
// Directed bench for lif_neuron_array: a timestep-level neuron model predicts the
// spike vectors, and a per-cycle checker compares REQ/NEURON_OUT/BUSY/EN_DROP.
module tb_lif_neuron_array;

   localparam int N = 16;

   logic           CLK = 1'b0;
   logic           RST;
   logic [N*7-1:0] NCFG;
   logic           PD, SWP, RESET_MODE, EN, FT, ACK;
   logic [5:0]     LEAK;
   logic [2:0]     REFRAC;
   logic [N*10-1:0] DV;
   logic           REQ, BUSY, EN_DROP;
   logic [N-1:0]   NEURON_OUT;

   lif_neuron_array dut (
      .CLK(CLK), .RST(RST), .NCFG(NCFG), .PD(PD), .SWP(SWP),
      .RESET_MODE(RESET_MODE), .LEAK(LEAK), .REFRAC(REFRAC), .EN(EN), .FT(FT),
      .DV(DV), .ACK(ACK), .REQ(REQ), .NEURON_OUT(NEURON_OUT), .BUSY(BUSY),
      .EN_DROP(EN_DROP)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   int mv[N];
   int mc[N];
   int vth[N];
   int dv[N];
   bit enb[N];

   logic         chk_on = 1'b0;
   logic         exp_req, exp_busy, exp_drop;
   logic [N-1:0] exp_out;

   function automatic int clampv(input int x);
      if (x > 63) return 63;
      if (x < -63) return -63;
      return x;
   endfunction

   // One timestep of the neuron rules in plain integer arithmetic.
   task automatic model_step(input bit ft, output logic [N-1:0] sp);
      int s, vt, lk;
      lk = int'(LEAK);
      sp = '0;
      for (int i = 0; i < N; i++) begin
         if (enb[i] || PD) continue;
         if (ft) begin
            mv[i] = 0;
            mc[i] = 0;
         end
         if (mc[i] == 0) begin
            s = clampv(mv[i] + dv[i]);
            if (s > lk) s = s - lk;
            else if (s < -lk) s = s + lk;
            else s = 0;
            mv[i] = s;
         end else begin
            mc[i] = mc[i] - 1;
         end
         vt = vth[i];
         if (mc[i] == 0 && (SWP ? (mv[i] <= -vt) : (mv[i] >= vt))) begin
            sp[i] = 1'b1;
            mv[i] = RESET_MODE ? clampv(SWP ? mv[i] + vt : mv[i] - vt) : 0;
            mc[i] = int'(REFRAC);
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = 0;
         mc[i] = 0;
      end
   endtask

   task automatic apply_inputs();
      for (int i = 0; i < N; i++) begin
         NCFG[i*7 +: 7] = {enb[i], 6'(vth[i])};
         DV[i*10 +: 10] = 10'(dv[i]);
      end
   endtask

   task automatic pin_v(input int i, input int val, input string name);
      tests++;
      if (mv[i] != val) begin
         fails++;
         $display("FAIL %s model v%0d=%0d required %0d", name, i, mv[i], val);
      end
   endtask

   // Starts at posedge+1 in IDLE and returns at posedge+1 in IDLE.
   task automatic do_step(input bit ft, input int hold, input int en_k, input int rst_k,
                          input bit en_with_ack, input logic [N-1:0] lit, input string name);
      logic [N-1:0] sp;
      apply_inputs();
      EN = 1'b1;
      FT = ft;
      @(posedge CLK); #1;
      EN = 1'b0;
      FT = 1'b0;
      exp_busy = 1'b1;
      model_step(ft, sp);
      tests++;
      if (sp !== lit) begin
         fails++;
         $display("FAIL %s model spikes=%h required %h", name, sp, lit);
      end
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      exp_req = 1'b1;
      exp_out = sp;
      for (int k = 0; k < hold; k++) begin
         if (k == rst_k) begin
            RST = 1'b1;
            exp_req = 1'b0; exp_out = '0; exp_busy = 1'b0; exp_drop = 1'b0;
            model_reset();
            @(posedge CLK); #1;
            RST = 1'b0;
            $display("[TB] %s: reset mid-OUT", name);
            return;
         end
         if (k == en_k) EN = 1'b1;
         @(posedge CLK); #1;
         if (EN) begin
            EN = 1'b0;
            exp_drop = 1'b1;
         end
      end
      ACK = 1'b1;
      if (en_with_ack) EN = 1'b1;
      @(posedge CLK); #1;
      ACK = 1'b0;
      if (EN) begin
         EN = 1'b0;
         exp_drop = 1'b1;
      end
      exp_req = 1'b0;
      exp_busy = 1'b0;
      $display("[TB] %s: ft=%0d dv0=%0d spikes=%h", name, ft, dv[0], sp);
   endtask

   always @(negedge CLK) begin
      if (chk_on) begin
         tests++;
         if (REQ !== exp_req || NEURON_OUT !== exp_out || BUSY !== exp_busy || EN_DROP !== exp_drop) begin
            fails++;
            $display("FAIL cycle_chk t=%0t REQ=%b req'd %b OUT=%h req'd %h BUSY=%b req'd %b EN_DROP=%b req'd %b",
                     $time, REQ, exp_req, NEURON_OUT, exp_out, BUSY, exp_busy, EN_DROP, exp_drop);
         end
      end
   end

   initial begin
      RST = 1'b1; PD = 1'b0; SWP = 1'b0; RESET_MODE = 1'b0; EN = 1'b0; FT = 1'b0;
      ACK = 1'b0; LEAK = '0; REFRAC = '0;
      for (int i = 0; i < N; i++) begin
         vth[i] = 20; dv[i] = 0; enb[i] = 1'b0;
      end
      model_reset();
      apply_inputs();
      exp_req = 1'b0; exp_out = '0; exp_busy = 1'b0; exp_drop = 1'b0;
      @(posedge CLK); #1;
      chk_on = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;

      // Basic fire, both reset modes
      vth[0] = 10; dv[0] = 12;
      do_step(1, 0, -1, -1, 0, 16'h0001, "fire_rm0");
      pin_v(0, 0, "fire_rm0");
      RESET_MODE = 1'b1;
      do_step(1, 0, -1, -1, 0, 16'h0001, "fire_rm1");
      pin_v(0, 2, "fire_rm1");
      dv[0] = 8;
      do_step(0, 0, -1, -1, 0, 16'h0001, "probe_rm1");
      pin_v(0, 0, "probe_rm1");

      // Saturation with inverted compare
      RESET_MODE = 1'b0; SWP = 1'b1; vth[0] = 5; dv[0] = 100;
      do_step(1, 0, -1, -1, 0, 16'h0000, "sat_pos");
      pin_v(0, 63, "sat_pos");
      dv[0] = -200;
      do_step(0, 0, -1, -1, 0, 16'h0001, "sat_neg");
      pin_v(0, 0, "sat_neg");

      // Leak and refractory
      SWP = 1'b0; LEAK = 6'd2; REFRAC = 3'd2; vth[0] = 4; dv[0] = 5;
      do_step(1, 0, -1, -1, 0, 16'h0000, "leak_s1");
      pin_v(0, 3, "leak_s1");
      do_step(0, 0, -1, -1, 0, 16'h0001, "leak_s2");
      dv[0] = 10;
      do_step(0, 0, -1, -1, 0, 16'h0000, "refr_s3");
      do_step(0, 0, -1, -1, 0, 16'h0000, "refr_s4");
      pin_v(0, 0, "refr_s4");
      do_step(0, 0, -1, -1, 0, 16'h0001, "refr_s5");
      REFRAC = 3'd0; dv[0] = -5;
      do_step(1, 0, -1, -1, 0, 16'h0000, "leak_neg");
      pin_v(0, -3, "leak_neg");
      dv[0] = 9;
      do_step(0, 0, -1, -1, 0, 16'h0001, "leak_neg_probe");

      // EN together with ACK in OUT is dropped
      LEAK = 6'd0; dv[0] = 0;
      do_step(1, 2, -1, -1, 1, 16'h0000, "en_with_ack");
      repeat (3) @(posedge CLK);
      #1;

      // Reset mid-OUT, then v starts from zero
      vth[0] = 10; dv[0] = 12;
      do_step(1, 5, -1, 3, 0, 16'h0001, "rst_mid_out");
      dv[0] = 3;
      do_step(0, 0, -1, -1, 0, 16'h0000, "post_rst");
      pin_v(0, 3, "post_rst");
      dv[0] = 7;
      do_step(0, 0, -1, -1, 0, 16'h0001, "post_rst_probe");

      // Backpressure with an EN pulse during OUT
      dv[0] = 12;
      do_step(1, 10, 2, -1, 0, 16'h0001, "backpressure");
      repeat (3) @(posedge CLK);
      #1;

      // Disabled neuron and power-down
      enb[3] = 1'b1; vth[3] = 1; dv[3] = 50;
      do_step(1, 0, -1, -1, 0, 16'h0001, "disable");
      pin_v(3, 0, "disable");
      enb[3] = 1'b0; dv[3] = -1; dv[0] = 0;
      do_step(0, 0, -1, -1, 0, 16'h0000, "disable_probe");
      PD = 1'b1;
      for (int i = 0; i < N; i++) dv[i] = 50;
      do_step(0, 1, -1, -1, 0, 16'h0000, "power_down");
      PD = 1'b0;
      for (int i = 0; i < N; i++) dv[i] = 0;
      do_step(0, 0, -1, -1, 0, 16'h0000, "pd_probe");
      pin_v(3, -1, "pd_probe");

      @(posedge CLK); #1;
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
